cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, the N-bit successor of the team's 4-bit CLA. Operands enter through a valid/ready handshake. Carries propagate group-to-group across pipeline stages, with operand skew and result deskew registers, so one operation is accepted per cycle. The block serves as the datapath adder for wider arithmetic units and streaming accumulators.

---
 rtl/cla_pipe_adder.sv | 138 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, GPS groups per stage.
// Define CLA_PIPE_OVF_EN to compile in signed-overflow detection; otherwise ovf is tied to 0.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned SW = 4 * GPS;
  localparam int unsigned S  = WIDTH / SW;

  // Level k (0..S-1) holds operands waiting for slice k; level S is the aligned result.
  logic [WIDTH-1:0] a_q   [S];
  logic [WIDTH-1:0] a_d   [S];
  logic [WIDTH-1:0] b_q   [S];
  logic [WIDTH-1:0] b_d   [S];
  logic [WIDTH-1:0] sum_q [S+1];
  logic [WIDTH-1:0] sum_d [S+1];
  logic [S:0]       c_q, c_d;
  logic [S:0]       v_q, v_d;
  logic             advance;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g, p, c;
    logic       co;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {co, p ^ c};
  endfunction

  assign advance  = !v_q[S] || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic           carry;
    logic [4:0]     r;
    int unsigned    idx;
    carry = 1'b0;
    r     = '0;
    idx   = 0;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    c_d   = c_q;
    v_d   = v_q;
    if (advance) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]   = A;
        b_d[0]   = sub ? ~B : B;
        c_d[0]   = Cin ^ sub;
        sum_d[0] = '0;
      end
      for (int unsigned j = 0; j < S; j++) begin
        carry      = c_q[j];
        sum_d[j+1] = sum_q[j];
        for (int unsigned g = 0; g < GPS; g++) begin
          idx                  = j * SW + g * 4;
          r                    = cla4(a_q[j][idx +: 4], b_q[j][idx +: 4], carry);
          sum_d[j+1][idx +: 4] = r[3:0];
          carry                = r[4];
        end
        c_d[j+1] = carry;
        v_d[j+1] = v_q[j];
        if (j + 1 < S) begin
          a_d[j+1] = a_q[j];
          b_d[j+1] = b_q[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= S; k++) begin
        sum_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  assign out_valid = v_q[S];
  assign Sum       = sum_q[S];
  assign Cout      = c_q[S];

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Sign bits of A and Beff ride with the final-stage operands.
  always_comb begin
    ovf_d = ovf_q;
    if (advance) begin
      ovf_d = (a_q[S-1][WIDTH-1] == b_q[S-1][WIDTH-1]) &&
              (sum_d[S][WIDTH-1] != a_q[S-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16, GPS=1): vector table, streaming with stall, mid-stream reset.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, ovf;
  logic [15:0] A, B, Sum;

  cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
    .Cout(Cout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sb;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co, ov;
    int          acc;
    bit          lat;
  } exp_t;

  vec_t tbl [10];
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_pop  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on every result beat the DUT hands over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_result", {16'h0, Sum}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("sum", {16'h0, Sum}, {16'h0, e.s});
          chk("cout", {31'h0, Cout}, {31'h0, e.co});
          chk("ovf", {31'h0, ovf}, {31'h0, e.ov});
          if (e.lat) chk("latency", cyc - e.acc, 4);
          n_pop++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic sb, input logic [15:0] es, input logic eco,
                      input logic eov, input bit lat);
    bit done, rdy;
    A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        sbq.push_back('{es, eco, eov & OvfEn, cyc, lat});
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 40 && !empty; t++) begin
      @(posedge clk);
      #2;
      if (sbq.size() == 0) empty = 1'b1;
    end
    if (!empty) chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    int          base;
    bit          got, seen;
    logic [15:0] held;

    tbl[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[2] = '{16'h000A, 16'h000F, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0};
    tbl[3] = '{16'h000F, 16'h000A, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    #1;
    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_sum", {16'h0, Sum}, 0);
    chk("reset_cout", {31'h0, Cout}, 0);
    chk("reset_ovf", {31'h0, ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", {31'h0, in_ready}, 1);

    // Isolated beats so each one's latency is exact.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sb, tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);
      in_valid = 1'b0;
      drain();
    end

    // Streaming with a 3-cycle downstream stall after the 2nd result.
    base = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(16'(i), 16'(i * 3), 1'b0, 1'b0, 16'(i * 4), 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
      end
      begin
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
          @(posedge clk);
          #1;
          if (n_pop == base + 2) got = 1'b1;
        end
        chk("stall_reached", {31'h0, got}, 1);
        if (got) begin
          out_ready = 1'b0;
          held = Sum;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'h0, in_ready}, 0);
            chk("stall_out_valid", {31'h0, out_valid}, 1);
            chk("stall_sum_held", {16'h0, Sum}, {16'h0, held});
          end
          @(posedge clk);
          #1 out_ready = 1'b1;
        end
      end
    join
    drain();
    chk("stream_count", n_pop - base, 8);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      send(16'h0100, 16'(i), 1'b0, 1'b0, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'h0, out_valid}, 0);
    chk("midreset_sum", {16'h0, Sum}, 0);
    chk("midreset_in_ready", {31'h0, in_ready}, 1);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("no_stale_beat", {31'h0, seen}, 0);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
